// File: rtl/demux_1to8_collector_if.sv
// Serial-in / parallel-out handshake bundle for the demux collector.
// The master modport is the collector itself; the slave modport is its environment.
interface demux_1to8_collector_if #(
   parameter int unsigned N     = 8,
   parameter int unsigned SEL_W = 3
);
   logic             in_bit;
   logic             in_valid;
   logic             in_ready;
   logic [SEL_W-1:0] sel_out;
   logic             flush;
   logic [N-1:0]     out_data;
   logic             out_valid;
   logic             out_ready;

   modport master (
      input  in_bit, in_valid, flush, out_ready,
      output in_ready, sel_out, out_data, out_valid
   );

   modport slave (
      output in_bit, in_valid, flush, out_ready,
      input  in_ready, sel_out, out_data, out_valid
   );
endinterface

// File: rtl/demux_1to8_collector.sv
// Collects N serial bits, slot-indexed by its own select output, and
// presents the reassembled word with a valid/ready handshake.
module demux_1to8_collector #(
   parameter int unsigned N     = 8,
   parameter int unsigned SEL_W = 3
) (
   input logic                    clk,
   input logic                    rst_n,
   demux_1to8_collector_if.master bus
);

   typedef enum logic {
      S_COLLECT,
      S_HOLD
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [SEL_W-1:0] r_sel;
   logic [N-1:0]     r_shadow;
   logic [N-1:0]     r_data;

   logic             w_in_ready;
   logic             w_out_valid;
   logic             w_last;
   logic             w_in_xfer;
   logic             w_out_xfer;
   logic [N-1:0]     w_word;

   // flush in COLLECT swallows any simultaneous input transfer
   assign w_last     = (r_sel == SEL_W'(N - 1));
   assign w_in_xfer  = (r_state == S_COLLECT) && bus.in_valid && !bus.flush;
   assign w_out_xfer = (r_state == S_HOLD) && bus.out_ready;

   always_comb begin
      w_word        = r_shadow;
      w_word[N-1]   = bus.in_bit;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_COLLECT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_COLLECT: if (w_in_xfer && w_last) w_state_nxt = S_HOLD;
         S_HOLD:    if (bus.out_ready)       w_state_nxt = S_COLLECT;
         default:                            w_state_nxt = S_COLLECT;
      endcase
   end

   always_comb begin
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      case (r_state)
         S_COLLECT: w_in_ready  = 1'b1;
         S_HOLD:    w_out_valid = 1'b1;
         default:   w_in_ready  = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sel    <= '0;
         r_shadow <= '0;
         r_data   <= '0;
      end else if (r_state == S_COLLECT) begin
         if (bus.flush) begin
            r_sel    <= '0;
            r_shadow <= '0;
         end else if (w_in_xfer) begin
            if (w_last) begin
               r_data <= w_word;
            end else begin
               r_shadow[r_sel] <= bus.in_bit;
               r_sel           <= r_sel + SEL_W'(1);
            end
         end
      end else if (w_out_xfer) begin
         r_sel    <= '0;
         r_shadow <= '0;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.sel_out   = r_sel;
   assign bus.out_data  = r_data;

endmodule

// File: tb/tb_demux_1to8_collector.sv
// Directed bench: an 8:1 mux loopback model feeds the collector from a test word.
module tb_demux_1to8_collector;

   logic       clk;
   logic       rst_n;
   logic [7:0] tb_word;
   int         n_checks;
   int         n_fail;

   demux_1to8_collector_if #(.N(8), .SEL_W(3)) bus ();

   demux_1to8_collector #(.N(8), .SEL_W(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // upstream mux model: collector's select picks the bit of the parallel word
   assign bus.in_bit = tb_word[bus.sel_out];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_word(input logic [7:0] w);
      tb_word      = w;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("sel_seq", 32'(bus.sel_out), 32'(i));
         tick();
      end
      bus.in_valid = 1'b0;
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      tb_word       = 8'h00;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_sel",       32'(bus.sel_out),   32'd0);
      check("rst_data",      32'(bus.out_data),  32'h00);
      rst_n = 1'b1;

      // loopback sweep, consumer always ready
      bus.out_ready = 1'b1;
      send_word(8'b10101010);
      check("loop_valid",    32'(bus.out_valid), 32'd1);
      check("loop_data",     32'(bus.out_data),  32'hAA);
      check("loop_sel_hold", 32'(bus.sel_out),   32'd7);
      check("loop_in_ready", 32'(bus.in_ready),  32'd0);
      tick();
      check("loop_valid_1cy", 32'(bus.out_valid), 32'd0);
      check("loop_sel_wrap",  32'(bus.sel_out),   32'd0);
      check("loop_data_keep", 32'(bus.out_data),  32'hAA);

      // backpressure with in_valid active during HOLD
      bus.out_ready = 1'b0;
      send_word(8'h3C);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid",    32'(bus.out_valid), 32'd1);
         check("bp_in_ready", 32'(bus.in_ready),  32'd0);
         check("bp_data",     32'(bus.out_data),  32'h3C);
         check("bp_sel",      32'(bus.sel_out),   32'd7);
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      check("bp_rel_valid", 32'(bus.out_valid), 32'd0);
      check("bp_rel_sel",   32'(bus.sel_out),   32'd0);
      check("bp_rel_rdy",   32'(bus.in_ready),  32'd1);
      check("bp_rel_data",  32'(bus.out_data),  32'h3C);

      // gapped input: valid pattern 1,0,0,1,0,0,...
      bus.out_ready = 1'b0;
      tb_word       = 8'hF0;
      for (int i = 0; i < 8; i++) begin
         bus.in_valid = 1'b1;
         check("gap_sel_pre", 32'(bus.sel_out), 32'(i));
         tick();
         if (i < 7) begin
            bus.in_valid = 1'b0;
            tick();
            tick();
            check("gap_sel_hold", 32'(bus.sel_out), 32'(i + 1));
            check("gap_no_valid", 32'(bus.out_valid), 32'd0);
         end
      end
      bus.in_valid = 1'b0;
      check("gap_valid", 32'(bus.out_valid), 32'd1);
      check("gap_data",  32'(bus.out_data),  32'hF0);
      bus.out_ready = 1'b1;
      tick();
      check("gap_rel_valid", 32'(bus.out_valid), 32'd0);

      // flush mid-word drops the concurrent bit and restarts at slot 0
      tb_word      = 8'hFF;
      bus.in_valid = 1'b1;
      repeat (4) tick();
      check("fl_sel4", 32'(bus.sel_out), 32'd4);
      bus.flush = 1'b1;
      tick();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      check("fl_sel0",  32'(bus.sel_out),   32'd0);
      check("fl_valid", 32'(bus.out_valid), 32'd0);
      bus.out_ready = 1'b0;
      send_word(8'h81);
      check("fl_data",       32'(bus.out_data),  32'h81);
      check("fl_data_valid", 32'(bus.out_valid), 32'd1);
      bus.out_ready = 1'b1;
      tick();

      // reset during HOLD discards the held word
      bus.out_ready = 1'b0;
      send_word(8'h55);
      check("rh_pre_data", 32'(bus.out_data), 32'h55);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("rh_valid",    32'(bus.out_valid), 32'd0);
      check("rh_data",     32'(bus.out_data),  32'h00);
      check("rh_sel",      32'(bus.sel_out),   32'd0);
      check("rh_in_ready", 32'(bus.in_ready),  32'd1);

      // reset mid-word at slot 5
      bus.out_ready = 1'b1;
      tb_word       = 8'h55;
      bus.in_valid  = 1'b1;
      repeat (5) tick();
      bus.in_valid = 1'b0;
      check("rm_sel5", 32'(bus.sel_out), 32'd5);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("rm_sel0", 32'(bus.sel_out), 32'd0);

      // flush during HOLD is ignored
      bus.out_ready = 1'b0;
      send_word(8'h99);
      bus.flush = 1'b1;
      tick();
      tick();
      check("fh_valid", 32'(bus.out_valid), 32'd1);
      check("fh_data",  32'(bus.out_data),  32'h99);
      check("fh_sel",   32'(bus.sel_out),   32'd7);
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      check("fh_rel_valid", 32'(bus.out_valid), 32'd0);
      check("fh_rel_sel",   32'(bus.sel_out),   32'd0);

      // back-to-back word after HOLD exit, shadow must start clean
      bus.out_ready = 1'b0;
      send_word(8'h12);
      check("b2b_data", 32'(bus.out_data), 32'h12);
      bus.out_ready = 1'b1;
      tick();
      check("b2b_rel", 32'(bus.out_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
